// File: rtl/multicycle_control.sv
// multicycle_control
//   Multi-cycle LEGv8 control sequencer. It steps each instruction through
//   FETCH, DECODE, EXEC, MEM and WB. It drives the datapath control fields,
//   the PC/IR write strobes and the handshaked instruction/data memory
//   requests. A watchdog aborts any memory wait that runs too long.
// Ports:
//   CLK, resetl                      clock, async active-low reset
//   opcode[10:0]                     IR[31:21], valid from DECODE onward
//   zero                             ALU zero flag, used by CBZ in EXEC
//   imem_ready, dmem_ready           memory handshake completions
//   imem_read, dmem_read, dmem_write memory requests
//   ir_write, pc_write, pc_src       IR/PC update controls
//   reg2loc, alusrc, mem2reg,
//   regwrite, aluop[3:0], signop[2:0] datapath controls
//   instr_done, illegal, bus_error   one-cycle status pulses
//   state[2:0]                       FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4
module multicycle_control #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_read,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg2loc,
    output logic        alusrc,
    output logic        mem2reg,
    output logic        regwrite,
    output logic [3:0]  aluop,
    output logic [2:0]  signop,
    output logic        instr_done,
    output logic        illegal,
    output logic        bus_error,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_AND, C_ORR, C_ADD, C_SUB, C_ADDI, C_SUBI, C_MOVZ,
        C_B, C_CBZ, C_LDUR, C_STUR, C_ILLEGAL
    } class_t;

    state_t           r_state;
    state_t           w_next;
    class_t           r_class;
    class_t           w_dec;
    logic [CNT_W-1:0] r_wd;
    logic             w_wait;
    logic             w_timeout;

    // Pattern order matters: the first matching entry wins.
    function automatic class_t decode_op(input logic [10:0] op);
        class_t c;
        casez (op)
            11'b?0001010???: c = C_AND;
            11'b?0101010???: c = C_ORR;
            11'b?0?01011???: c = C_ADD;
            11'b?1?01011???: c = C_SUB;
            11'b?0?10001???: c = C_ADDI;
            11'b?1?10001???: c = C_SUBI;
            11'b110100101??: c = C_MOVZ;
            11'b?00101?????: c = C_B;
            11'b?011010????: c = C_CBZ;
            11'b??111000010: c = C_LDUR;
            11'b??111000000: c = C_STUR;
            default:         c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    assign w_dec  = decode_op(opcode);
    assign w_wait = ((r_state == S_FETCH) && !imem_ready) ||
                    ((r_state == S_MEM)   && !dmem_ready);
    // A ready in the expiry cycle suppresses the timeout (w_wait is low).
    assign w_timeout = (TIMEOUT != 0) && w_wait && (r_wd == CNT_W'(TIMEOUT));
    assign state     = r_state;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_state <= S_FETCH;
            r_class <= C_NONE;
            r_wd    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_class <= w_dec;
            // Waiting implies staying in the same state, so any exit clears.
            if (w_wait && !w_timeout && (r_wd != '1))
                r_wd <= r_wd + CNT_W'(1);
            else if (!w_wait || w_timeout)
                r_wd <= '0;
        end
    end

    always_comb begin
        w_next     = r_state;
        imem_read  = 1'b0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg2loc    = 1'b0;
        alusrc     = 1'b0;
        mem2reg    = 1'b0;
        regwrite   = 1'b0;
        aluop      = '0;
        signop     = '0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        bus_error  = 1'b0;

        if ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)) begin
            case (r_class)
                C_AND:  aluop = 4'b0000;
                C_ORR:  aluop = 4'b0001;
                C_ADD:  aluop = 4'b0010;
                C_SUB:  aluop = 4'b0110;
                C_ADDI: begin aluop = 4'b0010; alusrc = 1'b1; end
                C_SUBI: begin aluop = 4'b0110; alusrc = 1'b1; end
                C_MOVZ: begin aluop = 4'b0111; alusrc = 1'b1; signop = 3'b100; end
                C_B:    signop = 3'b010;
                C_CBZ:  begin aluop = 4'b0111; signop = 3'b011; reg2loc = 1'b1; end
                C_LDUR: begin aluop = 4'b0010; alusrc = 1'b1; signop = 3'b001; end
                C_STUR: begin
                    aluop = 4'b0010; alusrc = 1'b1; signop = 3'b001; reg2loc = 1'b1;
                end
                default: ;
            endcase
        end

        case (r_state)
            S_FETCH: begin
                // FETCH is the reset state; keep the request quiet while held in reset.
                imem_read = resetl;
                if (resetl && imem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end else if (resetl && w_timeout) begin
                    bus_error = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_DECODE: begin
                if (w_dec == C_ILLEGAL) begin
                    illegal = 1'b1;
                    w_next  = S_FETCH;
                end else begin
                    w_next  = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_class)
                    C_B: begin
                        pc_write   = 1'b1;
                        pc_src     = 1'b1;
                        instr_done = 1'b1;
                        w_next     = S_FETCH;
                    end
                    C_CBZ: begin
                        pc_write   = zero;
                        pc_src     = zero;
                        instr_done = 1'b1;
                        w_next     = S_FETCH;
                    end
                    C_LDUR, C_STUR: w_next = S_MEM;
                    C_AND, C_ORR, C_ADD, C_SUB, C_ADDI, C_SUBI, C_MOVZ: w_next = S_WB;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                dmem_read  = (r_class == C_LDUR);
                dmem_write = (r_class == C_STUR);
                if (dmem_ready) begin
                    if (r_class == C_LDUR) begin
                        w_next = S_WB;
                    end else begin
                        instr_done = (r_class == C_STUR);
                        w_next     = S_FETCH;
                    end
                end else if (w_timeout) begin
                    bus_error = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_WB: begin
                regwrite   = 1'b1;
                mem2reg    = (r_class == C_LDUR);
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule
